led_pwm_ctrl: RTL and testbench

Register-driven multi-channel PWM LED driver on the PL side of the Zynq design. Sits directly downstream of the AXI-lite register file. It consumes control, period, prescale and duty words from `slv_reg`, drives the board `led` pins, and returns a status word into `slv_read`. All settings are shadowed and committed only at PWM period boundaries, so software writes never glitch an output.

---
 rtl/led_pwm_pkg.sv | 31 +++
 rtl/led_pwm_ctrl_if.sv | 19 +
 rtl/led_pwm_ctrl_channel.sv | 66 ++++++
 rtl/led_pwm_ctrl.sv | 108 ++++++++++
 tb/tb_led_pwm_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared constants and types for the led_pwm_ctrl block.
//   NCH / CNT_W / PRE_W     channel count, PWM counter width, prescaler width
//   CTRL_*                  bit positions inside the 32-bit control word
//   ST_*                    field offsets inside the 32-bit status word
//   ctrl_t                  packed view of the control word
// Optional feature macro used by this block: LED_PWM_BREATHE_EN.
package led_pwm_pkg;
    localparam int NCH    = 4;
    localparam int CNT_W  = 16;
    localparam int PRE_W  = 16;
    localparam int WRAP_W = 8;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_INV      = 1;
    localparam int CTRL_CHEN_LSB = 4;
    localparam int CTRL_BR_LSB   = 12;

    localparam int ST_CNT_LSB  = 0;
    localparam int ST_LED_LSB  = 16;
    localparam int ST_WRAP_LSB = 24;

    typedef struct packed {
        logic [31:CTRL_BR_LSB+NCH]             rsvd_hi;
        logic [NCH-1:0]                        breathe;
        logic [CTRL_BR_LSB-1:CTRL_CHEN_LSB+NCH] rsvd_mid;
        logic [NCH-1:0]                        chan_en;
        logic [CTRL_CHEN_LSB-1:2]              rsvd_lo;
        logic                                  invert;
        logic                                  enable;
    } ctrl_t;
endpackage

// File: rtl/led_pwm_ctrl_if.sv
// led_pwm_ctrl_if: register-file side of the PWM LED driver.
//   ctrl, prescale, period, duty   settings from slv_reg (master -> slave)
//   led, period_tick, status       outputs / readback (slave -> master)
interface led_pwm_ctrl_if;
    import led_pwm_pkg::*;

    logic [31:0]          ctrl;
    logic [PRE_W-1:0]     prescale;
    logic [CNT_W-1:0]     period;
    logic [NCH*CNT_W-1:0] duty;
    logic [NCH-1:0]       led;
    logic                 period_tick;
    logic [31:0]          status;

    modport master (output ctrl, prescale, period, duty,
                    input  led, period_tick, status);
    modport slave  (input  ctrl, prescale, period, duty,
                    output led, period_tick, status);
endinterface

// File: rtl/led_pwm_ctrl_channel.sv
// pwm_channel: one PWM output channel.
//   clk, rst_n   clock, async active-low reset
//   enable       global enable; while low the duty shadow tracks its input
//   wrap         PWM period boundary; duty shadow commits here
//   chan_en      channel enable (unshadowed)
//   duty_in      requested duty, pwm_cnt shared PWM counter
//   breathe, period_act  only with LED_PWM_BREATHE_EN
//   raw          unregistered compare result
module pwm_channel
    import led_pwm_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             wrap,
    input  logic             chan_en,
    input  logic [CNT_W-1:0] duty_in,
    input  logic [CNT_W-1:0] pwm_cnt,
`ifdef LED_PWM_BREATHE_EN
    input  logic             breathe,
    input  logic [CNT_W-1:0] period_act,
`endif
    output logic             raw
);
    logic [CNT_W-1:0] duty_act;
    logic [CNT_W-1:0] duty_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            duty_act <= '0;
        else if (!enable || wrap)
            duty_act <= duty_in;
    end

`ifdef LED_PWM_BREATHE_EN
    // Triangle ramp: climbs one step per period until it passes period_act,
    // then descends to 0 and climbs again.
    logic [CNT_W-1:0] ramp;
    logic             ramp_dn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramp    <= '0;
            ramp_dn <= 1'b0;
        end else if (!enable || !breathe) begin
            ramp    <= '0;
            ramp_dn <= 1'b0;
        end else if (wrap) begin
            if (!ramp_dn) begin
                ramp <= ramp + CNT_W'(1);
                if (ramp >= period_act) ramp_dn <= 1'b1;
            end else begin
                ramp <= ramp - CNT_W'(1);
                if (ramp <= CNT_W'(1)) ramp_dn <= 1'b0;
            end
        end
    end

    assign duty_eff = breathe ? ramp : duty_act;
`else
    assign duty_eff = duty_act;
`endif

    // duty > period gives 100%, duty == 0 gives 0%, both fall out of the compare
    assign raw = chan_en && (pwm_cnt < duty_eff);
endmodule

// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: multi-channel PWM LED driver fed from the AXI-lite register file.
//   axi_aclk, axi_aresetn   clock, async active-low reset
//   bus (slave modport)     ctrl/prescale/period/duty in; led/period_tick/status out
// prescale, period and duty are shadowed and commit only at a PWM wrap;
// invert and chan_en act on the next clock.
// Optional macro LED_PWM_BREATHE_EN builds the per-channel breathe ramps
// (ctrl[15:12]); without it those bits are ignored.
module led_pwm_ctrl
    import led_pwm_pkg::*;
(
    input logic           axi_aclk,
    input logic           axi_aresetn,
    led_pwm_ctrl_if.slave bus
);
    ctrl_t              c;
    logic               enable, invert;
    logic [NCH-1:0]     chan_en;
    logic [PRE_W-1:0]   pre_cnt, prescale_act;
    logic [CNT_W-1:0]   pwm_cnt, period_act;
    logic [WRAP_W-1:0]  wrap_cnt;
    logic               tick, wrap;
    logic [NCH-1:0]     raw, led_d;
    logic [31:0]        status_d;

    assign c       = ctrl_t'(bus.ctrl);
    assign enable  = c.enable;
    assign invert  = c.invert;
    assign chan_en = c.chan_en;

`ifdef LED_PWM_BREATHE_EN
    logic unused_ctrl;
    assign unused_ctrl = ^{c.rsvd_hi, c.rsvd_mid, c.rsvd_lo};
`else
    logic unused_ctrl;
    assign unused_ctrl = ^{c.rsvd_hi, c.breathe, c.rsvd_mid, c.rsvd_lo};
`endif

    assign tick = enable && (pre_cnt == prescale_act);
    assign wrap = tick && (pwm_cnt == period_act);

    // Prescaler, PWM counter, wrap counter and the period/prescale shadows.
    // While disabled the shadows follow the inputs so the first period after
    // enable runs with whatever software has already written.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pre_cnt      <= '0;
            pwm_cnt      <= '0;
            wrap_cnt     <= '0;
            prescale_act <= '0;
            period_act   <= '0;
        end else if (!enable) begin
            pre_cnt      <= '0;
            pwm_cnt      <= '0;
            prescale_act <= bus.prescale;
            period_act   <= bus.period;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (wrap) begin
                pwm_cnt      <= '0;
                wrap_cnt     <= wrap_cnt + WRAP_W'(1);
                prescale_act <= bus.prescale;
                period_act   <= bus.period;
            end else if (tick) begin
                pwm_cnt <= pwm_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_channel u_ch (
            .clk        (axi_aclk),
            .rst_n      (axi_aresetn),
            .enable     (enable),
            .wrap       (wrap),
            .chan_en    (chan_en[i]),
            .duty_in    (bus.duty[i*CNT_W +: CNT_W]),
            .pwm_cnt    (pwm_cnt),
`ifdef LED_PWM_BREATHE_EN
            .breathe    (c.breathe[i]),
            .period_act (period_act),
`endif
            .raw        (raw[i])
        );
    end

    // Disabled forces the pins low regardless of invert.
    assign led_d = enable ? (raw ^ {NCH{invert}}) : '0;

    always_comb begin
        status_d = '0;
        status_d[ST_CNT_LSB  +: CNT_W]  = pwm_cnt;
        status_d[ST_LED_LSB  +: NCH]    = led_d;
        status_d[ST_WRAP_LSB +: WRAP_W] = wrap_cnt;
    end

    // period_tick is registered on the same edge that returns pwm_cnt to 0.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            bus.led         <= '0;
            bus.period_tick <= 1'b0;
            bus.status      <= '0;
        end else begin
            bus.led         <= led_d;
            bus.period_tick <= wrap;
            bus.status      <= status_d;
        end
    end
endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb_led_pwm_ctrl: randomized scoreboard bench for led_pwm_ctrl.
// A reference model tracks committed settings per PWM period and pushes the
// expected period length, per-channel high-clock counts and wrap count; a
// monitor measures each period between period_tick pulses and compares.
module tb_led_pwm_ctrl;
    import led_pwm_pkg::*;

    typedef struct packed {
        logic [31:0]           len;
        logic [NCH-1:0][31:0]  hi;
        logic [7:0]            wrap;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    led_pwm_ctrl_if bus ();
    led_pwm_ctrl dut (.axi_aclk(clk), .axi_aresetn(rst_n), .bus(bus));

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // model state
    bit                   en_q = 0, en_first = 0, have_prev = 0;
    int                   rem = 0, cur_pre = 0, cur_per = 0;
    logic [NCH*CNT_W-1:0] cur_duty = '0;
    logic [7:0]           m_wrap = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t calc(input int pre, input int per, input logic [NCH*CNT_W-1:0] d,
                                  input logic inv, input logic [NCH-1:0] chen, input logic [7:0] w);
        exp_t e;
        int   len, on, dv;
        len    = (pre + 1) * (per + 1);
        e.len  = 32'(len);
        e.wrap = w;
        for (int i = 0; i < NCH; i++) begin
            dv = int'(d[i*CNT_W +: CNT_W]);
            on = chen[i] ? (pre + 1) * ((dv < per + 1) ? dv : per + 1) : 0;
            e.hi[i] = 32'(inv ? len - on : on);
        end
        return e;
    endfunction

    // Reference model: a period lasts (pre+1)*(per+1) clocks of the settings
    // committed at its start; settings present at the wrap clock commit.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            sb.delete(); en_q = 0; en_first = 0; have_prev = 0; m_wrap = '0;
        end else if (!bus.ctrl[CTRL_EN]) begin
            sb.delete(); en_q = 0; en_first = 0; have_prev = 0;
        end else begin
            en_first = !en_q;
            if (!en_q) begin
                cur_pre = int'(bus.prescale); cur_per = int'(bus.period); cur_duty = bus.duty;
                rem = (cur_pre + 1) * (cur_per + 1);
            end
            en_q = 1;
            rem--;
            if (rem == 0) begin
                if (have_prev)
                    sb.push_back(calc(cur_pre, cur_per, cur_duty, bus.ctrl[CTRL_INV],
                                      bus.ctrl[CTRL_CHEN_LSB +: NCH], m_wrap));
                m_wrap    = m_wrap + 8'd1;
                have_prev = 1;
                cur_pre = int'(bus.prescale); cur_per = int'(bus.period); cur_duty = bus.duty;
                rem = (cur_pre + 1) * (cur_per + 1);
            end
        end
    end

    // Monitor: measure each full period between period_tick pulses.
    initial begin
        bit   arm = 0, prev_dis = 0;
        int   acc_len = 0;
        int   acc_hi[NCH];
        exp_t e;
        foreach (acc_hi[i]) acc_hi[i] = 0;
        forever begin
            @(negedge clk);
            if (!en_q) begin
                check("disabled_led", 64'(bus.led), 64'(0));
                check("disabled_tick", 64'(bus.period_tick), 64'(0));
                if (prev_dis)
                    check("disabled_status", 64'(bus.status), 64'({m_wrap, 24'h0}));
                prev_dis = 1; arm = 0; acc_len = 0;
                foreach (acc_hi[i]) acc_hi[i] = 0;
            end else begin
                prev_dis = 0;
                if (en_first)
                    check("restart_cnt", 64'(bus.status[ST_CNT_LSB +: CNT_W]), 64'(0));
                acc_len++;
                foreach (acc_hi[i]) acc_hi[i] += int'(bus.led[i]);
                if (bus.period_tick) begin
                    if (arm) begin
                        if (sb.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL scoreboard_empty: actual tick expected none at %0t", $time);
                        end else begin
                            e = sb.pop_front();
                            check("period_len", 64'(acc_len), 64'(e.len));
                            for (int i = 0; i < NCH; i++)
                                check($sformatf("led%0d_high", i), 64'(acc_hi[i]), 64'(e.hi[i]));
                            check("wrap_cnt", 64'(bus.status[ST_WRAP_LSB +: 8]), 64'(e.wrap));
                        end
                    end
                    arm = 1; acc_len = 0;
                    foreach (acc_hi[i]) acc_hi[i] = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [NCH*CNT_W-1:0] mk_duty(input int a, input int b, input int c, input int d);
        logic [NCH*CNT_W-1:0] v;
        v = {CNT_W'(d), CNT_W'(c), CNT_W'(b), CNT_W'(a)};
        return v;
    endfunction

    task automatic start(input int pre, input int per, input logic [NCH*CNT_W-1:0] d,
                         input logic inv, input logic [NCH-1:0] chen);
        logic [31:0] cw;
        cw = '0;
        cw[CTRL_INV] = inv;
        cw[CTRL_CHEN_LSB +: NCH] = chen;
        bus.ctrl = cw; bus.prescale = PRE_W'(pre); bus.period = CNT_W'(per); bus.duty = d;
        cyc(3);
        bus.ctrl[CTRL_EN] = 1'b1;
    endtask

    task automatic run(input int n, input bit mutate);
        int ch;
        for (int k = 0; k < n; k++) begin
            cyc(1);
            if (mutate && $urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 2))
                    0: bus.period   = CNT_W'($urandom_range(0, 12));
                    1: bus.prescale = PRE_W'($urandom_range(0, 2));
                    default: begin
                        ch = int'($urandom_range(0, NCH - 1));
                        bus.duty[ch*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 14));
                    end
                endcase
            end
        end
    endtask

    task automatic stop();
        bus.ctrl[CTRL_EN] = 1'b0;
        cyc(3);
    endtask

    initial begin
        // reset with random inputs
        bus.ctrl = $urandom; bus.prescale = PRE_W'($urandom); bus.period = CNT_W'($urandom);
        bus.duty = {$urandom, $urandom};
        #2 rst_n = 1'b0;
        #1;
        check("reset_led", 64'(bus.led), 64'(0));
        check("reset_status", 64'(bus.status), 64'(0));
        check("reset_tick", 64'(bus.period_tick), 64'(0));
        cyc(2);
        bus.ctrl = '0;
        cyc(1);
        rst_n = 1'b1;
        cyc(10);
        check("idle_status", 64'(bus.status), 64'(0));

        // basic PWM: 3 of 10
        start(0, 9, mk_duty(3, 0, 0, 0), 1'b0, 4'b0001); run(60, 0); stop();

        // shadowing: two writes in one period, then a period change
        start(0, 9, mk_duty(3, 0, 0, 0), 1'b0, 4'b0001);
        run(13, 0); bus.duty[0 +: CNT_W] = CNT_W'(5);
        run(3, 0);  bus.duty[0 +: CNT_W] = CNT_W'(7);
        run(25, 0); bus.period = CNT_W'(4);
        run(40, 0); stop();

        // boundaries
        start(0, 9, mk_duty(0, 0, 0, 0), 1'b0, 4'b0001);  run(40, 0); stop();
        start(0, 9, mk_duty(10, 0, 0, 0), 1'b0, 4'b0001); run(40, 0); stop();
        start(0, 0, mk_duty(1, 0, 1, 0), 1'b0, 4'b0101);  run(300, 0); stop();
        start(0, 9, mk_duty(3, 0, 0, 0), 1'b1, 4'b0001);  run(40, 0); stop();
        start(2, 9, mk_duty(3, 5, 9, 12), 1'b0, 4'b1111); run(130, 0); stop();

        // reset mid-period, then restart
        start(1, 6, mk_duty(2, 4, 6, 8), 1'b0, 4'b1111); run(23, 0);
        rst_n = 1'b0; bus.ctrl[CTRL_EN] = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        bus.ctrl[CTRL_EN] = 1'b1; run(60, 0); stop();

        // randomized phases with mid-period writes
        for (int p = 0; p < 8; p++) begin
            start(int'($urandom_range(0, 2)), int'($urandom_range(0, 12)),
                  mk_duty(int'($urandom_range(0, 14)), int'($urandom_range(0, 14)),
                          int'($urandom_range(0, 14)), int'($urandom_range(0, 14))),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            run(220, 1); stop();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
